digit_show_queue: RTL

DIGIT_SHOW_QUEUE -- requirements
Module: digit_show_queue

---
 rtl/digit_show_queue.sv | 134 +++++++++++++
 1 files changed

// File: rtl/digit_show_queue.sv
// Queues single-cycle digit strobes in a 4-deep FIFO and shows each on a seven-segment display.
// Define HEX_GLYPHS_EN to render 10-15 as A,b,C,d,E,F instead of a dash.
module digit_show_queue #(
  parameter int SHOW_TICKS  = 500,
  parameter int BLANK_TICKS = 100
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] in_digit,
  input  logic       in_valid,
  output logic [6:0] segments,
  output logic       dp,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;

  localparam logic [15:0] SHOW_LOAD  = 16'(SHOW_TICKS - 1);
  localparam logic [15:0] BLANK_LOAD = 16'(BLANK_TICKS - 1);

  state_t      state_q, state_d;
  logic [15:0] tick_q, tick_d;
  logic [3:0]  fifo_q [4];
  logic [1:0]  rd_q, wr_q;
  logic [2:0]  cnt_q, cnt_d;
  logic [3:0]  disp_q, disp_d;
  logic        ovf_q;
  logic [6:0]  seg_q;
  logic        pop, push, drop;

  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
`ifdef HEX_GLYPHS_EN
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      4'hF: s = 7'h71;
`endif
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    disp_d  = disp_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cnt_q != 3'd0) begin
          pop     = 1'b1;
          state_d = SHOW;
          tick_d  = SHOW_LOAD;
        end
      end
      SHOW: begin
        if (tick_q == 16'd0) begin
          state_d = BLANK;
          tick_d  = BLANK_LOAD;
        end else begin
          tick_d = tick_q - 16'd1;
        end
      end
      BLANK: begin
        if (tick_q != 16'd0) begin
          tick_d = tick_q - 16'd1;
        end else if (cnt_q != 3'd0) begin
          pop     = 1'b1;
          state_d = SHOW;
          tick_d  = SHOW_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (pop) disp_d = fifo_q[rd_q];
  end

  // a pop frees a slot in the same cycle, so a full FIFO can still accept
  assign push = in_valid && ((cnt_q != 3'd4) || pop);
  assign drop = in_valid && !push;

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop) cnt_d = cnt_q + 3'd1;
    else if (pop && !push) cnt_d = cnt_q - 3'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      tick_q  <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      disp_q  <= '0;
      ovf_q   <= 1'b0;
      seg_q   <= '0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
      // decode the next display value so the pattern lands with the state
      seg_q   <= (state_d == SHOW) ? decode(disp_d) : 7'h00;
      if (drop) ovf_q <= 1'b1;
      if (push) begin
        fifo_q[wr_q] <= in_digit;
        wr_q         <= wr_q + 2'd1;
      end
      if (pop) rd_q <= rd_q + 2'd1;
    end
  end

  assign segments = seg_q;
  assign dp       = ovf_q;
  assign busy     = (state_q != IDLE) || (cnt_q != 3'd0);

endmodule
